// File: rtl/alu16_if.sv
// Operand/result bundle for alu16: operands and opcode in, registered results out.
interface alu16_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ins;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] hi;
  logic [2:0]       flags;

  modport master (output A, B, ins, input out, hi, flags);
  modport slave  (input A, B, ins, output out, hi, flags);
endinterface

// File: rtl/alu16.sv
// Registered 16-bit signed ALU with one cycle of latency.
// Define ALU_DIV_EN to build the divider; otherwise opcode 4 behaves as a NOP.
module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic   clk,
  input  logic   rst_n,
  alu16_if.slave bus
);

  localparam int W = WIDTH;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIV = 4'd4;
`endif
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_XOR = 4'd8;
  localparam logic [3:0] OP_CMP = 4'd9;

  logic signed [W-1:0]   a;
  logic signed [W-1:0]   b;
  logic [W-1:0]          sum;
  logic [W-1:0]          diff;
  logic signed [2*W-1:0] a_ext;
  logic signed [2*W-1:0] b_ext;
  logic signed [2*W-1:0] prod;
  logic                  mul_fits;
  logic                  cmp_gt;
  logic                  cmp_eq;

  logic [W-1:0] next_out;
  logic [W-1:0] next_hi;
  logic         next_ovf;
  logic         next_dz;

  assign a     = bus.A;
  assign b     = bus.B;
  assign sum   = bus.A + bus.B;
  assign diff  = bus.A - bus.B;
  assign a_ext = {{W{a[W-1]}}, a};
  assign b_ext = {{W{b[W-1]}}, b};
  assign prod  = a_ext * b_ext;

  // Product fits in W signed bits when its upper half plus the low sign bit are all equal.
  assign mul_fits = (&prod[2*W-1:W-1]) | ~(|prod[2*W-1:W-1]);
  assign cmp_gt   = a > b;
  assign cmp_eq   = a == b;

`ifdef ALU_DIV_EN
  logic [W-1:0]   a_mag;
  logic [W-1:0]   b_mag;
  logic [2*W-1:0] qr_mag;
  logic [W-1:0]   div_q;
  logic [W-1:0]   div_r;
  logic           div_min_case;

  // Restoring division on magnitudes; returns {remainder, quotient}.
  function automatic logic [2*W-1:0] udiv(input logic [W-1:0] n, input logic [W-1:0] d);
    logic [W:0]   r;
    logic [W-1:0] q;
    r = '0;
    q = '0;
    for (int i = W - 1; i >= 0; i--) begin
      r = {r[W-1:0], n[i]};
      if (r >= {1'b0, d}) begin
        r    = r - {1'b0, d};
        q[i] = 1'b1;
      end
    end
    return {r[W-1:0], q};
  endfunction

  // The most negative value has no positive twin, but its magnitude still fits as unsigned.
  assign a_mag  = a[W-1] ? (~bus.A + 1'b1) : bus.A;
  assign b_mag  = b[W-1] ? (~bus.B + 1'b1) : bus.B;
  assign qr_mag = udiv(a_mag, b_mag);
  assign div_q  = (a[W-1] ^ b[W-1]) ? (~qr_mag[W-1:0] + 1'b1) : qr_mag[W-1:0];
  assign div_r  = a[W-1] ? (~qr_mag[2*W-1:W] + 1'b1) : qr_mag[2*W-1:W];
  assign div_min_case = (bus.A == {1'b1, {(W-1){1'b0}}}) && (bus.B == {W{1'b1}});
`endif

  always_comb begin
    next_out = '0;
    next_hi  = '0;
    next_ovf = 1'b0;
    next_dz  = 1'b0;
    case (bus.ins)
      OP_ADD: begin
        next_out = sum;
        next_ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
      end
      OP_SUB: begin
        next_out = diff;
        next_ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]);
      end
      OP_MUL: begin
        next_out = prod[W-1:0];
        next_hi  = prod[2*W-1:W];
        next_ovf = ~mul_fits;
      end
`ifdef ALU_DIV_EN
      OP_DIV: begin
        if (bus.B == '0) begin
          next_hi = bus.A;
          next_dz = 1'b1;
        end else begin
          // MIN / -1 wraps back to MIN with a zero remainder, which the magnitude path yields.
          next_out = div_q;
          next_hi  = div_r;
          next_ovf = div_min_case;
        end
      end
`endif
      OP_OR:  next_out = bus.A | bus.B;
      OP_AND: next_out = bus.A & bus.B;
      OP_NOT: next_out = ~bus.A;
      OP_XOR: next_out = bus.A ^ bus.B;
      OP_CMP: next_out = cmp_gt ? {{(W-1){1'b0}}, 1'b1} : (cmp_eq ? '0 : {W{1'b1}});
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out   <= '0;
      bus.hi    <= '0;
      bus.flags <= '0;
    end else begin
      bus.out   <= next_out;
      bus.hi    <= next_hi;
      bus.flags <= {next_out == '0, next_dz, next_ovf};
    end
  end

endmodule

// File: tb/tb_alu16.sv
// Self-checking bench for alu16: directed test-plan cases plus randomized ops vs an arithmetic model.
module tb_alu16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu16_if bus ();

  alu16 u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive an operation after the falling edge and return just after the capturing rising edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op);
    @(negedge clk);
    bus.A   = a;
    bus.B   = b;
    bus.ins = op;
    @(posedge clk);
    #1;
  endtask

  // Reference computed with plain integer arithmetic.
  function automatic void model(input logic [15:0] a, input logic [15:0] b, input logic [3:0] op,
                                output logic [15:0] eo, output logic [15:0] eh, output logic [2:0] ef);
    int sa;
    int sb;
    int r;
    int m;
    sa = $signed(a);
    sb = $signed(b);
    eo = '0;
    eh = '0;
    ef = '0;
    case (op)
      4'd1: begin r = sa + sb; eo = r[15:0]; ef[0] = (r > 32767) || (r < -32768); end
      4'd2: begin r = sa - sb; eo = r[15:0]; ef[0] = (r > 32767) || (r < -32768); end
      4'd3: begin r = sa * sb; eo = r[15:0]; eh = r[31:16]; ef[0] = (r > 32767) || (r < -32768); end
`ifdef ALU_DIV_EN
      4'd4: begin
        if (sb == 0) begin
          eh = a;
          ef[1] = 1'b1;
        end else if (sa == -32768 && sb == -1) begin
          eo = 16'h8000;
          ef[0] = 1'b1;
        end else begin
          r = sa / sb;
          m = sa % sb;
          eo = r[15:0];
          eh = m[15:0];
        end
      end
`endif
      4'd5: eo = a | b;
      4'd6: eo = a & b;
      4'd7: eo = ~a;
      4'd8: eo = a ^ b;
      4'd9: eo = (sa > sb) ? 16'd1 : ((sa == sb) ? 16'd0 : 16'hFFFF);
      default: ;
    endcase
    ef[2] = (eo == 16'd0);
  endfunction

  function automatic logic [15:0] rand_operand();
    logic [15:0] corners [6] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001, 16'h0002};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return 16'($urandom());
  endfunction

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.A   = '0;
    bus.B   = '0;
    bus.ins = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out !== 16'd0 || bus.hi !== 16'd0 || bus.flags !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_init: got out=%h hi=%h flags=%b, expected 0/0/000", bus.out, bus.hi, bus.flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'd300, 16'd300, 4'd3);
    checks++;
    if (bus.out !== 16'd24464 || bus.hi !== 16'd1) begin
      errors++;
      $display("[TB] FAIL reset_preload: got out=%h hi=%h, expected 5f90/0001", bus.out, bus.hi);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out !== 16'd0 || bus.hi !== 16'd0 || bus.flags !== 3'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: got out=%h hi=%h flags=%b, expected 0/0/000", bus.out, bus.hi, bus.flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'd3, 16'd511, 4'd1);
    checks++;
    if (bus.out !== 16'd514 || bus.flags !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_release: got out=%h flags=%b, expected 0202/000", bus.out, bus.flags);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_out [9] = '{16'd514, 16'hFE04, 16'd1533, 16'd0, 16'd511, 16'd3, 16'hFFFC, 16'd508, 16'hFFFF};
    logic [15:0] exp_hi  [9];
    logic [2:0]  exp_fl  [9] = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
    exp_hi = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
`ifdef ALU_DIV_EN
    exp_hi[3] = 16'd3;
`endif
    for (int i = 0; i < 9; i++) begin
      applyStimulus(16'd3, 16'd511, 4'(i + 1));
      checks++;
      if (bus.out !== exp_out[i] || bus.hi !== exp_hi[i] || bus.flags !== exp_fl[i]) begin
        errors++;
        $display("[TB] FAIL seq_op%0d: got out=%h hi=%h flags=%b, expected %h/%h/%b",
                 i + 1, bus.out, bus.hi, bus.flags, exp_out[i], exp_hi[i], exp_fl[i]);
      end
    end
  endtask

  task automatic test_edges();
    logic [15:0] ta [11] = '{16'd32767, 16'h8000, 16'd300, 16'hFFFE, 16'hFFF9, 16'd5, 16'h8000,
                             16'd7, 16'hFFFF, 16'd9, 16'd0};
    logic [15:0] tb [11] = '{16'd1, 16'd1, 16'd300, 16'd3, 16'd2, 16'd0, 16'hFFFF,
                             16'd7, 16'd0, 16'd4, 16'd0};
    logic [3:0]  tins [11] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd9, 4'd9, 4'd12, 4'd15};
    logic [15:0] eo [11] = '{16'h8000, 16'h7FFF, 16'd24464, 16'hFFFA, 16'hFFFD, 16'd0, 16'h8000,
                             16'd0, 16'hFFFF, 16'd0, 16'd0};
    logic [15:0] eh [11] = '{16'd0, 16'd0, 16'd1, 16'hFFFF, 16'hFFFF, 16'd5, 16'd0,
                             16'd0, 16'd0, 16'd0, 16'd0};
    logic [2:0]  ef [11] = '{3'b001, 3'b001, 3'b001, 3'b000, 3'b000, 3'b110, 3'b001,
                             3'b100, 3'b000, 3'b100, 3'b100};
`ifndef ALU_DIV_EN
    for (int i = 4; i < 7; i++) begin
      eo[i] = 16'd0;
      eh[i] = 16'd0;
      ef[i] = 3'b100;
    end
`endif
    for (int i = 0; i < 11; i++) begin
      applyStimulus(ta[i], tb[i], tins[i]);
      checks++;
      if (bus.out !== eo[i] || bus.hi !== eh[i] || bus.flags !== ef[i]) begin
        errors++;
        $display("[TB] FAIL edge%0d(ins=%0d A=%h B=%h): got out=%h hi=%h flags=%b, expected %h/%h/%b",
                 i, tins[i], ta[i], tb[i], bus.out, bus.hi, bus.flags, eo[i], eh[i], ef[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  op;
    logic [15:0] eo;
    logic [15:0] eh;
    logic [2:0]  ef;
    for (int i = 0; i < 400; i++) begin
      a  = rand_operand();
      b  = rand_operand();
      op = 4'($urandom_range(0, 15));
      model(a, b, op, eo, eh, ef);
      applyStimulus(a, b, op);
      checks++;
      if (bus.out !== eo || bus.hi !== eh || bus.flags !== ef) begin
        errors++;
        $display("[TB] FAIL rand%0d(ins=%0d A=%h B=%h): got out=%h hi=%h flags=%b, expected %h/%h/%b",
                 i, op, a, b, bus.out, bus.hi, bus.flags, eo, eh, ef);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_back_to_back();
    test_edges();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
